// File: rtl/semaforo_monitor.sv
// semaforo_monitor
//   Lamp-side checker for the semaforo traffic-light controller. It measures
//   how long each lamp colour is held and checks that length against the
//   programmed duration. It also checks the colour order red -> green ->
//   yellow -> red. Each ended phase gets a one-cycle report, and errors
//   accumulate in sticky fault bits.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   enable              monitor active; 0 forces IDLE
//   maintenance         controller in manual mode; 1 forces IDLE
//   red/yellow/green    observed lamp outputs
//   *_duration          programmed phase lengths in cycles
//   clear_faults        clears fault / fault_code at the next edge
//   phase_done          one-cycle pulse: a lamp phase just ended
//   phase_color         colour of ended phase (1 red, 2 yellow, 3 green)
//   phase_len           cycles the ended phase was held
//   duration_err        pulse: phase_len differs from programmed duration
//   order_err           pulse: new colour is not the legal successor
//   illegal_err         pulse: two or more lamps on, or all off while tracking
//   fault, fault_code   sticky error summary, code = {illegal, order, duration}
//   cycle_count         completed red->green transitions while tracking
//   state_dbg           current FSM state (0 IDLE, 1 SYNC, 2 TRACK)
module semaforo_monitor #(
    parameter int WIDTH = 32,
    parameter int CYC_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             maintenance,
    input  logic             red,
    input  logic             yellow,
    input  logic             green,
    input  logic [WIDTH-1:0] red_duration,
    input  logic [WIDTH-1:0] yellow_duration,
    input  logic [WIDTH-1:0] green_duration,
    input  logic             clear_faults,
    output logic             phase_done,
    output logic [1:0]       phase_color,
    output logic [WIDTH-1:0] phase_len,
    output logic             duration_err,
    output logic             order_err,
    output logic             illegal_err,
    output logic             fault,
    output logic [2:0]       fault_code,
    output logic [CYC_W-1:0] cycle_count,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SYNC  = 2'd1,
        ST_TRACK = 2'd2
    } state_t;

    // Colour codes double as the phase_color encoding (low two bits).
    localparam logic [2:0] C_OFF = 3'd0;
    localparam logic [2:0] C_RED = 3'd1;
    localparam logic [2:0] C_YEL = 3'd2;
    localparam logic [2:0] C_GRN = 3'd3;
    localparam logic [2:0] C_ILL = 3'd4;

    state_t           state;
    logic [2:0]       cur_code;
    logic [WIDTH-1:0] count;

    logic [2:0]       code;
    logic             active;
    logic             cur_is_color;
    logic             new_is_color;
    logic [2:0]       exp_next;
    logic [WIDTH-1:0] dur_sel;
    logic [WIDTH-1:0] count_inc;
    logic             change;
    logic             report;
    logic             checked;
    logic             e_dur;
    logic             e_ord;
    logic             e_ill;
    logic [2:0]       faults_next;

    always_comb begin
        case ({red, yellow, green})
            3'b000:  code = C_OFF;
            3'b100:  code = C_RED;
            3'b010:  code = C_YEL;
            3'b001:  code = C_GRN;
            default: code = C_ILL;
        endcase
    end

    always_comb begin
        exp_next = C_OFF;
        dur_sel  = '0;
        case (cur_code)
            C_RED: begin exp_next = C_GRN; dur_sel = red_duration;    end
            C_GRN: begin exp_next = C_YEL; dur_sel = green_duration;  end
            C_YEL: begin exp_next = C_RED; dur_sel = yellow_duration; end
            default: begin exp_next = C_OFF; dur_sel = '0; end
        endcase
    end

    always_comb begin
        active       = enable && !maintenance;
        cur_is_color = (cur_code == C_RED) || (cur_code == C_YEL) || (cur_code == C_GRN);
        new_is_color = (code == C_RED) || (code == C_YEL) || (code == C_GRN);
        // A saturated count stays at all-ones and is compared as such.
        count_inc    = (&count) ? count : count + WIDTH'(1);
        change       = active && (state != ST_IDLE) && (code != cur_code);
        report       = change && cur_is_color;
        // Only a colour-to-colour change while tracking is checked; the first
        // (partial) phase and phases cut short by OFF/ILLEGAL are not.
        checked      = report && (state == ST_TRACK) && new_is_color;
        e_dur        = checked && (count != dur_sel);
        e_ord        = checked && (code != exp_next);
        // Fires only on entry into the bad code, so a held combo pulses once.
        e_ill        = change && ((code == C_ILL) || ((code == C_OFF) && (state == ST_TRACK)));
        // A new error at the same edge as clear_faults wins.
        faults_next  = (clear_faults ? 3'b000 : fault_code) | {e_ill, e_ord, e_dur};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            cur_code     <= C_OFF;
            count        <= '0;
            phase_done   <= 1'b0;
            phase_color  <= 2'd0;
            phase_len    <= '0;
            duration_err <= 1'b0;
            order_err    <= 1'b0;
            illegal_err  <= 1'b0;
            fault        <= 1'b0;
            fault_code   <= 3'b000;
            cycle_count  <= '0;
        end else begin
            phase_done   <= 1'b0;
            duration_err <= 1'b0;
            order_err    <= 1'b0;
            illegal_err  <= 1'b0;
            fault_code   <= faults_next;
            fault        <= |faults_next;

            if (!active) begin
                // The interrupted phase is discarded without a report.
                state    <= ST_IDLE;
                cur_code <= C_OFF;
                count    <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (new_is_color) begin
                            state    <= ST_SYNC;
                            cur_code <= code;
                            count    <= WIDTH'(1);
                        end
                    end
                    default: begin
                        if (!change) begin
                            count <= count_inc;
                        end else begin
                            cur_code    <= code;
                            count       <= WIDTH'(1);
                            illegal_err <= e_ill;
                            if (report) begin
                                phase_done   <= 1'b1;
                                phase_color  <= cur_code[1:0];
                                phase_len    <= count;
                                duration_err <= e_dur;
                                order_err    <= e_ord;
                            end
                            if (new_is_color) begin
                                // After OFF/ILLEGAL the new colour phase is partial.
                                state <= cur_is_color ? ST_TRACK : ST_SYNC;
                                if (state == ST_TRACK && cur_code == C_RED && code == C_GRN)
                                    cycle_count <= cycle_count + CYC_W'(1);
                            end else begin
                                state <= ST_SYNC;
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_semaforo_monitor.sv
module tb_semaforo_monitor;

    localparam int WIDTH = 32;
    localparam int CYC_W = 16;

    logic             clk;
    logic             rst_n;
    logic             enable;
    logic             maintenance;
    logic             red, yellow, green;
    logic [WIDTH-1:0] red_duration, yellow_duration, green_duration;
    logic             clear_faults;
    logic             phase_done;
    logic [1:0]       phase_color;
    logic [WIDTH-1:0] phase_len;
    logic             duration_err, order_err, illegal_err;
    logic             fault;
    logic [2:0]       fault_code;
    logic [CYC_W-1:0] cycle_count;
    logic [1:0]       state_dbg;

    int n_checks = 0;
    int n_errors = 0;

    // Report observations gathered while stepping.
    int         n_done, n_derr, n_oerr, n_ierr;
    logic [1:0] last_color;
    logic [31:0] last_len;

    semaforo_monitor #(.WIDTH(WIDTH), .CYC_W(CYC_W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .enable          (enable),
        .maintenance     (maintenance),
        .red             (red),
        .yellow          (yellow),
        .green           (green),
        .red_duration    (red_duration),
        .yellow_duration (yellow_duration),
        .green_duration  (green_duration),
        .clear_faults    (clear_faults),
        .phase_done      (phase_done),
        .phase_color     (phase_color),
        .phase_len       (phase_len),
        .duration_err    (duration_err),
        .order_err       (order_err),
        .illegal_err     (illegal_err),
        .fault           (fault),
        .fault_code      (fault_code),
        .cycle_count     (cycle_count),
        .state_dbg       (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_obs();
        n_done = 0; n_derr = 0; n_oerr = 0; n_ierr = 0;
    endtask

    // Advance n rising edges; outputs are sampled 1 time unit after each edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (phase_done) begin
                n_done++;
                last_color = phase_color;
                last_len   = phase_len;
            end
            n_derr += int'(duration_err);
            n_oerr += int'(order_err);
            n_ierr += int'(illegal_err);
        end
    endtask

    task automatic phase(input logic r, input logic y, input logic g, input int n);
        red = r; yellow = y; green = g;
        step(n);
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; maintenance = 1'b0; clear_faults = 1'b0;
        red = 1'b0; yellow = 1'b0; green = 1'b0;
        red_duration = 32'd10; yellow_duration = 32'd3; green_duration = 32'd7;
        last_color = 2'd0; last_len = 32'd0;
        clear_obs();

        #12;
        check("rst_phase_done", {31'd0, phase_done}, 32'd0);
        check("rst_phase_len", phase_len, 32'd0);
        check("rst_fault_code", {29'd0, fault_code}, 32'd0);
        check("rst_cycle_count", {16'd0, cycle_count}, 32'd0);
        check("rst_state", {30'd0, state_dbg}, 32'd0);

        @(posedge clk); #1;
        rst_n = 1'b1; enable = 1'b1;

        // Clean run R10 G7 Y3 x3.
        phase(1, 0, 0, 10);
        phase(0, 0, 1, 1);
        check("first_done", {31'd0, phase_done}, 32'd1);
        check("first_color", {30'd0, phase_color}, 32'd1);
        check("first_len", phase_len, 32'd10);
        check("first_state_track", {30'd0, state_dbg}, 32'd2);
        phase(0, 0, 1, 6);
        phase(0, 1, 0, 3);
        phase(1, 0, 0, 10); phase(0, 0, 1, 7); phase(0, 1, 0, 3);
        phase(1, 0, 0, 10); phase(0, 0, 1, 7); phase(0, 1, 0, 3);
        phase(1, 0, 0, 1);
        check("clean_reports", n_done, 32'd9);
        check("clean_derr", n_derr, 32'd0);
        check("clean_oerr", n_oerr, 32'd0);
        check("clean_ierr", n_ierr, 32'd0);
        check("clean_cycles", {16'd0, cycle_count}, 32'd2);
        check("clean_fault", {31'd0, fault}, 32'd0);
        check("clean_last_color", {30'd0, last_color}, 32'd2);
        check("clean_last_len", last_len, 32'd3);

        // Short green: G held 6, programmed 7.
        phase(1, 0, 0, 9);
        phase(0, 0, 1, 6);
        phase(0, 1, 0, 1);
        check("short_done", {31'd0, phase_done}, 32'd1);
        check("short_color", {30'd0, phase_color}, 32'd3);
        check("short_len", phase_len, 32'd6);
        check("short_derr", {31'd0, duration_err}, 32'd1);
        check("short_fault_code", {29'd0, fault_code}, 32'd1);
        check("short_cycles", {16'd0, cycle_count}, 32'd3);

        // Order violation: R then Y.
        phase(0, 1, 0, 2);
        phase(1, 0, 0, 10);
        phase(0, 1, 0, 1);
        check("order_err", {31'd0, order_err}, 32'd1);
        check("order_derr", {31'd0, duration_err}, 32'd0);
        check("order_fault_code", {29'd0, fault_code}, 32'd3);
        phase(0, 1, 0, 2);
        phase(1, 0, 0, 1);
        check("after_order_done", {31'd0, phase_done}, 32'd1);
        check("after_order_oerr", {31'd0, order_err}, 32'd0);
        check("after_order_derr", {31'd0, duration_err}, 32'd0);
        phase(1, 0, 0, 9);
        phase(0, 0, 1, 5);
        check("order_cycles", {16'd0, cycle_count}, 32'd4);

        // clear_faults at the same edge as a duration error, then alone.
        clear_faults = 1'b1;
        phase(0, 1, 0, 1);
        check("clr_same_derr", {31'd0, duration_err}, 32'd1);
        check("clr_same_fault", {31'd0, fault}, 32'd1);
        check("clr_same_code", {29'd0, fault_code}, 32'd1);
        step(1);
        check("clr_lone_fault", {31'd0, fault}, 32'd0);
        check("clr_lone_code", {29'd0, fault_code}, 32'd0);
        clear_faults = 1'b0;
        step(1);
        phase(1, 0, 0, 4);

        // Illegal combo red+yellow for 2 cycles mid-red.
        clear_obs();
        phase(1, 1, 0, 2);
        check("ill_pulses", n_ierr, 32'd1);
        check("ill_reports", n_done, 32'd1);
        check("ill_len", last_len, 32'd4);
        check("ill_unchecked", n_derr, 32'd0);
        check("ill_state_sync", {30'd0, state_dbg}, 32'd1);
        check("ill_fault_code", {29'd0, fault_code}, 32'd4);
        phase(1, 0, 0, 6);
        phase(0, 0, 1, 1);
        check("ill_next_done", {31'd0, phase_done}, 32'd1);
        check("ill_next_len", phase_len, 32'd6);
        check("ill_next_derr", {31'd0, duration_err}, 32'd0);
        check("ill_next_state", {30'd0, state_dbg}, 32'd2);
        check("ill_next_cycles", {16'd0, cycle_count}, 32'd4);

        // Maintenance mid-red with manual R+Y lamps.
        phase(0, 0, 1, 6);
        phase(0, 1, 0, 3);
        phase(1, 0, 0, 4);
        clear_obs();
        maintenance = 1'b1;
        phase(1, 1, 0, 10);
        check("maint_reports", n_done, 32'd0);
        check("maint_errs", n_derr + n_oerr + n_ierr, 32'd0);
        check("maint_state_idle", {30'd0, state_dbg}, 32'd0);
        maintenance = 1'b0;
        phase(1, 0, 0, 1);
        check("maint_resync", {30'd0, state_dbg}, 32'd1);
        phase(1, 0, 0, 9);
        phase(0, 0, 1, 1);
        check("maint_first_len", phase_len, 32'd10);
        check("maint_first_derr", {31'd0, duration_err}, 32'd0);
        check("maint_cycles", {16'd0, cycle_count}, 32'd4);
        check("maint_fault_code", {29'd0, fault_code}, 32'd4);

        // Asynchronous reset mid-phase.
        phase(0, 0, 1, 3);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_len", phase_len, 32'd0);
        check("arst_color", {30'd0, phase_color}, 32'd0);
        check("arst_fault", {31'd0, fault}, 32'd0);
        check("arst_fault_code", {29'd0, fault_code}, 32'd0);
        check("arst_cycles", {16'd0, cycle_count}, 32'd0);
        check("arst_state", {30'd0, state_dbg}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/semaforo_monitor.md
# semaforo_monitor

Lamp-side checker for the `semaforo` traffic-light controller. It observes the `red`/`yellow`/`green` outputs and measures each phase length in clock cycles. It checks lengths against the programmed durations and the phase order against red → green → yellow → red, and reports per-phase results plus sticky fault status. It sits beside `semaforo` on the same clock and is used both in-system and as a bench scoreboard.

## Interface
- `WIDTH`, 32, width of duration inputs and measured phase length.
- `CYC_W`, 16, width of completed-cycle counter.

- `clk` in 1, system clock; all logic on rising edge.
- `rst_n` in 1, asynchronous active-low reset.
- `enable` in 1, monitor active (tied to controller `start`); 0 forces IDLE.
- `maintenance` in 1, controller in manual mode; 1 forces IDLE, no checks.
- `red`, `yellow`, `green` in 1 each, observed lamp outputs.
- `red_duration`, `yellow_duration`, `green_duration` in WIDTH, programmed phase lengths, same values as given to the controller.
- `clear_faults` in 1, clears `fault` and `fault_code`.
- `phase_done` out 1, one-cycle pulse: a lamp phase just ended.
- `phase_color` out 2, color of ended phase: 1 red, 2 yellow, 3 green (0 never valid with `phase_done`).
- `phase_len` out WIDTH, cycles the ended phase was held.
- `duration_err` out 1, pulse with `phase_done`: `phase_len` ≠ programmed duration.
- `order_err` out 1, pulse: new color is not the legal successor.
- `illegal_err` out 1, pulse: ≥2 lamps on, or all off while tracking.
- `fault` out 1, sticky OR of all error pulses.
- `fault_code` out 3, sticky {illegal, order, duration} bits.
- `cycle_count` out CYC_W, completed red→green transitions in TRACK; wraps.

## Operation
- Lamp code per edge: OFF (000), RED, YELLOW, GREEN (one-hot), ILLEGAL (≥2 set).
- Registers: `cur_code`, `count` (WIDTH, saturates at all-ones), state.
- Same code as `cur_code`: `count` += 1. Different code: `cur_code` ← new code, `count` ← 1. If the old code was a color, emit a phase report with `phase_len` = old `count` and `phase_color` = old color.
- States:
  - IDLE: entered on reset, on `enable`=0, or on `maintenance`=1. `count` and `cur_code` are held cleared. No reports or errors. Leave to SYNC when `enable`=1, `maintenance`=0 and the code is a color.
  - SYNC: the first phase is partial. At its end, report with `duration_err`=0 and no order check, then go to TRACK.
  - TRACK:
    - Each report is checked: `duration_err` if `phase_len` ≠ the duration for that color.
    - Legal successors: RED→GREEN, GREEN→YELLOW, YELLOW→RED. Any other new color gives `order_err` in the cycle of the report; stay in TRACK.
    - RED→GREEN increments `cycle_count`.
- OFF in TRACK (with `enable`=1, `maintenance`=0): `illegal_err`, report the ended phase unchecked, go to SYNC.
- ILLEGAL code while `enable`=1 and `maintenance`=0, in SYNC or TRACK: `illegal_err`, report the ended phase unchecked, go to SYNC. ILLEGAL in IDLE is ignored.
- `maintenance` or `enable` change mid-phase: go to IDLE immediately. The interrupted phase is discarded and no report is made.
- Durations are sampled at the moment of comparison; changing them mid-phase affects only later checks.
- Saturated `count` compares as all-ones.

## Timing
- Reset values of all outputs are 0; state is IDLE.
- Lamp inputs are sampled at each rising edge. A lamp stable for N sampling edges yields `phase_len` = N.
- Report latency: lamps change before edge k. At edge k the new code is captured, and `phase_done`, `phase_color`, `phase_len` and the error pulses are valid from edge k to edge k+1. `phase_color` and `phase_len` hold until the next report.
- `fault` and `fault_code` update at the same edge as the pulse. `clear_faults` takes effect at the next edge. A new error at the same edge as `clear_faults` wins, and the bit is set.
- `cycle_count` updates at the edge of the RED→GREEN report.
- Asynchronous reset mid-phase clears everything at once. No report is made for the interrupted phase.

## Test plan
- Clean run with durations 10/3/7 and lamps driven R10 G7 Y3 ×3 cycles: first report is unchecked. Every later report has `duration_err`=0 and `order_err`=0. `cycle_count`=2 (first RED was SYNC), `fault`=0.
- Short green: G held 6 with programmed 7 → `phase_done` with `phase_color`=3, `phase_len`=6, `duration_err`=1, `fault_code`=001.
- Order violation: R then Y in TRACK → `order_err`=1 at the R report edge, `fault_code` bit1 set. The next Y→R is accepted normally.
- Illegal combo: `red`=`yellow`=1 for 2 cycles mid-phase → one `illegal_err` pulse, state SYNC. The following phase is reported unchecked.
- Maintenance mid-red: `maintenance`=1 after 4 red cycles, then manual lamps R+Y for 10 cycles, then release → no reports and no errors during maintenance. Re-enters through SYNC.
- `clear_faults` at the same edge as a `duration_err` → `fault` stays 1. A lone `clear_faults` one cycle later → `fault`=0, `fault_code`=000. Asserting `rst_n`=0 mid-phase → all outputs 0 asynchronously.
